// File: rtl/logic_reduce_pipe_pkg.sv
// logic_reduce_pipe_pkg
//   Shared types for the logic reduce cells.
//   logic_op_t : 3-bit operation select (AND/OR/XOR, their inversions,
//                PASS of operand 0, ZERO).
//   state_t    : output-stage occupancy (EMPTY, ONE, TWO).
package logic_reduce_pipe_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_PASS = 3'b110,
    OP_ZERO = 3'b111
  } logic_op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/logic_reduce_comb.sv
// logic_reduce_comb
//   Purely combinational bitwise reducer over INPUTS operands of BITS width.
//   Parameters: BITS (operand/result width), INPUTS (operand count, >=2).
//   Ports:
//     op       in  3              operation select (logic_op_t encoding)
//     operands in  INPUTS*BITS    operand i at [i*BITS +: BITS]
//     result   out BITS           reduced result
//   Inversions are applied after the full reduction.
module logic_reduce_comb
  import logic_reduce_pipe_pkg::*;
#(
  parameter int BITS   = 1,
  parameter int INPUTS = 3
) (
  input  logic [2:0]             op,
  input  logic [INPUTS*BITS-1:0] operands,
  output logic [BITS-1:0]        result
);

  logic [BITS-1:0] and_r;
  logic [BITS-1:0] or_r;
  logic [BITS-1:0] xor_r;

  always_comb begin
    and_r = operands[BITS-1:0];
    or_r  = operands[BITS-1:0];
    xor_r = operands[BITS-1:0];
    for (int i = 1; i < INPUTS; i++) begin
      and_r = and_r & operands[i*BITS +: BITS];
      or_r  = or_r  | operands[i*BITS +: BITS];
      xor_r = xor_r ^ operands[i*BITS +: BITS];
    end
  end

  always_comb begin
    result = '0;
    case (logic_op_t'(op))
      OP_AND:  result = and_r;
      OP_OR:   result = or_r;
      OP_XOR:  result = xor_r;
      OP_NAND: result = ~and_r;
      OP_NOR:  result = ~or_r;
      OP_XNOR: result = ~xor_r;
      OP_PASS: result = operands[BITS-1:0];
      OP_ZERO: result = '0;
      default: result = '0;
    endcase
  end

`ifdef FORMAL
  // Reference built from per-bit ones counts rather than chained gates.
  logic [BITS-1:0] ref_r;
  int              ones;
  always_comb begin
    ref_r = '0;
    ones  = 0;
    for (int b = 0; b < BITS; b++) begin
      ones = 0;
      for (int i = 0; i < INPUTS; i++) ones = ones + int'(operands[i*BITS + b]);
      case (op)
        3'b000:  ref_r[b] = (ones == INPUTS);
        3'b001:  ref_r[b] = (ones != 0);
        3'b010:  ref_r[b] = ones[0];
        3'b011:  ref_r[b] = (ones != INPUTS);
        3'b100:  ref_r[b] = (ones == 0);
        3'b101:  ref_r[b] = ~ones[0];
        3'b110:  ref_r[b] = operands[b];
        default: ref_r[b] = 1'b0;
      endcase
    end
    assert (result == ref_r);
  end
`endif

endmodule

// File: rtl/logic_reduce_pipe.sv
// logic_reduce_pipe
//   Registered N-input bitwise logic cell with valid/ready on both sides.
//   Parameters: BITS (operand/result width), INPUTS (operand count).
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     in_valid/in_ready       upstream handshake
//     in_op, in_operands      operation select, packed operands
//     out_valid/out_ready     downstream handshake
//     out_result, out_op      buffered result and the op that made it
//     dbg_state               occupancy state (state_t encoding)
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both high; a source holding valid keeps its payload stable until taken.
//   Build option LOGIC_REDUCE_PIPE_SKID_EN: two-entry skid buffer with a
//   registered in_ready. Without it a single output register is used and
//   in_ready = ~out_valid | out_ready.
module logic_reduce_pipe
  import logic_reduce_pipe_pkg::*;
#(
  parameter int BITS   = 1,
  parameter int INPUTS = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [INPUTS*BITS-1:0] in_operands,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        out_result,
  output logic [2:0]             out_op,
  output logic [1:0]             dbg_state
);

  state_t          state_q, state_d;
  logic [BITS-1:0] main_res_q, main_res_d;
  logic [2:0]      main_op_q, main_op_d;
  logic [BITS-1:0] new_res;
  logic            accept;
  logic            drain;

  logic_reduce_comb #(.BITS(BITS), .INPUTS(INPUTS)) u_comb (
    .op       (in_op),
    .operands (in_operands),
    .result   (new_res)
  );

  assign out_valid  = (state_q != EMPTY);
  assign out_result = main_res_q;
  assign out_op     = main_op_q;
  assign dbg_state  = state_q;
  assign accept     = in_valid & in_ready;
  assign drain      = out_valid & out_ready;

`ifdef LOGIC_REDUCE_PIPE_SKID_EN
  logic [BITS-1:0] skid_res_q, skid_res_d;
  logic [2:0]      skid_op_q, skid_op_d;
  logic            in_ready_q;

  assign in_ready = in_ready_q;
`else
  assign in_ready = ~out_valid | out_ready;
`endif

  always_comb begin
    state_d    = state_q;
    main_res_d = main_res_q;
    main_op_d  = main_op_q;
`ifdef LOGIC_REDUCE_PIPE_SKID_EN
    skid_res_d = skid_res_q;
    skid_op_d  = skid_op_q;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_res_d = new_res;
          main_op_d  = in_op;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_res_d = new_res;
          main_op_d  = in_op;
        end else if (accept) begin
`ifdef LOGIC_REDUCE_PIPE_SKID_EN
          // Main is stalled: park the newcomer behind it.
          skid_res_d = new_res;
          skid_op_d  = in_op;
          state_d    = TWO;
`else
          main_res_d = new_res;
          main_op_d  = in_op;
`endif
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
`ifdef LOGIC_REDUCE_PIPE_SKID_EN
      TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          main_res_d = skid_res_q;
          main_op_d  = skid_op_q;
          state_d    = ONE;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      main_res_q <= '0;
      main_op_q  <= 3'b000;
    end else begin
      state_q    <= state_d;
      main_res_q <= main_res_d;
      main_op_q  <= main_op_d;
    end
  end

`ifdef LOGIC_REDUCE_PIPE_SKID_EN
  // in_ready is precomputed from the next state so it comes straight off a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_res_q <= '0;
      skid_op_q  <= 3'b000;
      in_ready_q <= 1'b1;
    end else begin
      skid_res_q <= skid_res_d;
      skid_op_q  <= skid_op_d;
      in_ready_q <= (state_d != TWO);
    end
  end
`endif

`ifdef FORMAL
  a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_result) && $stable(out_op)));
  a_no_accept_two: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == TWO) |-> !in_ready);
`endif

endmodule

// File: tb/tb_logic_reduce_pipe.sv
module tb_logic_reduce_pipe;
  localparam int BITS   = 4;
  localparam int INPUTS = 3;
  localparam int W      = BITS + 3;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [2:0]             in_op = 3'b000;
  logic [INPUTS*BITS-1:0] in_operands = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [BITS-1:0]        out_result;
  logic [2:0]             out_op;
  logic [1:0]             dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   tbl [8];

  logic_reduce_pipe #(.BITS(BITS), .INPUTS(INPUTS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_operands (in_operands),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_op      (out_op),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: per-bit count of ones across the operands.
  function automatic logic [BITS-1:0] ref_reduce(input logic [2:0] op,
                                                 input logic [INPUTS*BITS-1:0] opr);
    logic [BITS-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < BITS; b++) begin
      ones = 0;
      for (int i = 0; i < INPUTS; i++) ones += int'(opr[i*BITS + b]);
      case (op)
        3'd0:    r[b] = (ones == INPUTS);
        3'd1:    r[b] = (ones > 0);
        3'd2:    r[b] = (ones % 2 == 1);
        3'd3:    r[b] = (ones != INPUTS);
        3'd4:    r[b] = (ones == 0);
        3'd5:    r[b] = (ones % 2 == 0);
        3'd6:    r[b] = opr[b];
        default: r[b] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic model_ready();
`ifdef LOGIC_REDUCE_PIPE_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [3:0] a2, input logic ordy);
    in_valid    = v;
    in_op       = op;
    in_operands = {a2, a1, a0};
    out_ready   = ordy;
  endtask

  task automatic drive_rand(input int pv, input int pr);
    in_valid    = ($urandom_range(0, 99) < pv);
    in_op       = 3'($urandom_range(0, 7));
    in_operands = 12'($urandom_range(0, 4095));
    out_ready   = ($urandom_range(0, 99) < pr);
  endtask

  // One clock: check outputs at negedge, update the model at posedge.
  task automatic step();
    logic acc, drn;
    @(negedge clk);
    check_val("out_valid", out_valid, exp_q.size() > 0);
    check_val("in_ready", in_ready, model_ready());
    if (exp_q.size() > 0) begin
      check_val("out_result", out_result, exp_q[0][BITS-1:0]);
      check_val("out_op", out_op, exp_q[0][W-1:BITS]);
    end
    acc = in_valid && model_ready();
    drn = (exp_q.size() > 0) && out_ready;
    @(posedge clk);
    if (drn) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({in_op, ref_reduce(in_op, in_operands)});
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl = '{4'h2, 4'hF, 4'hF, 4'hD, 4'h0, 4'h0, 4'hA, 4'h0};

    // reset state
    #12;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_result", out_result, 0);
    check_val("rst_out_op", out_op, 0);
    release_reset();
    check_val("rst_in_ready", in_ready, 1);

    // NAND over F, F, 3
    drive(1'b1, 3'b011, 4'hF, 4'hF, 4'h3, 1'b1);
    step();
    check_val("nand_valid", out_valid, 1);
    check_val("nand_result", out_result, 4'hC);
    check_val("nand_op", out_op, 3'b011);

    // every op over A, 6, 3
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, 3'(op), 4'hA, 4'h6, 4'h3, 1'b1);
      step();
      check_val($sformatf("op_tbl_%0d", op), out_result, tbl[op]);
    end
    drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
    step();

    // 8 back-to-back
    for (int i = 0; i < 8; i++) begin
      drive_rand(100, 100);
      step();
      check_val("stream_in_ready", in_ready, 1);
    end
    drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
    step();

    // stall: two offers with out_ready low, then release
    drive(1'b1, 3'b001, 4'h1, 4'h2, 4'h4, 1'b0);
    step();
    drive(1'b1, 3'b000, 4'hF, 4'h7, 4'h3, 1'b0);
    step();
`ifdef LOGIC_REDUCE_PIPE_SKID_EN
    check_val("skid_in_ready_low", in_ready, 0);
`endif
    drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0, 1'b0);
    step();
    step();
    check_val("stall_hold_result", out_result, 4'h7);
    out_ready = 1'b1;
    step();
    step();
    step();
    check_val("after_drain_in_ready", in_ready, 1);

`ifndef LOGIC_REDUCE_PIPE_SKID_EN
    // replace in place while draining
    drive(1'b1, 3'b010, 4'h1, 4'h1, 4'h1, 1'b1);
    step();
    drive(1'b1, 3'b110, 4'h9, 4'h0, 4'h0, 1'b1);
    #1;
    check_val("comb_in_ready", in_ready, 1);
    step();
    check_val("replace_result", out_result, 4'h9);
    drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
    step();
`endif

    // reset while full
    drive(1'b1, 3'b011, 4'h5, 4'h5, 4'h5, 1'b0);
    step();
    step();
`ifdef LOGIC_REDUCE_PIPE_SKID_EN
    check_val("pre_rst_two", dbg_state, 2);
`endif
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_out_result", out_result, 0);
    check_val("midrst_out_op", out_op, 0);
    check_val("midrst_state", dbg_state, 0);
    exp_q.delete();
    release_reset();
    check_val("postrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drive_rand((i < 750) ? 80 : 40, (i < 750) ? 40 : 85);
      step();
    end

    // drain
    drive(1'b0, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check_val("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
